// File: rtl/fifo_pixel_drain.sv
// Read-side consumer for the coordinate FIFO: pops X then Y and presents each pair as one pixel point.
// Optional macro PIXEL_CLIP_EN drops points outside H_RES x V_RES and counts them on o_clip_count.
module fifo_pixel_drain #(
    parameter int DATA_W = 11,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_fifo_data,
    input  logic              i_fifo_empty,
    output logic              o_fifo_read,
    output logic [DATA_W-1:0] o_px_x,
    output logic [DATA_W-1:0] o_px_y,
    output logic              o_px_valid,
    input  logic              i_px_ready,
    output logic              o_busy,
`ifdef PIXEL_CLIP_EN
    output logic [CNT_W-1:0]  o_clip_count,
`endif
    output logic [CNT_W-1:0]  o_point_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP_X = 3'd1;
    localparam logic [2:0] S_CAP_X = 3'd2;
    localparam logic [2:0] S_POP_Y = 3'd3;
    localparam logic [2:0] S_CAP_Y = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

`ifdef PIXEL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [DATA_W-1:0] x_hold;
    logic              x_latched;
    logic              restart;
    logic              out_of_range;
    logic              drop_point;

    assign restart      = i_enable && !i_fifo_empty;
    assign out_of_range = (int'(x_hold) >= H_RES) || (int'(i_fifo_data) >= V_RES);
    // Constant-false when clipping is compiled out, so the comparators vanish.
    assign drop_point   = CLIP_EN && out_of_range;
    assign o_busy       = (state != S_IDLE);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (restart) state_next = S_POP_X;
            S_POP_X: state_next = S_CAP_X;
            S_CAP_X: if (!i_fifo_empty) state_next = S_POP_Y;
            S_POP_Y: state_next = S_CAP_Y;
            S_CAP_Y: begin
                if (drop_point) state_next = restart ? S_POP_X : S_IDLE;
                else            state_next = S_OUT;
            end
            S_OUT:   if (i_px_ready) state_next = restart ? S_POP_X : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            o_fifo_read   <= 1'b0;
            x_hold        <= '0;
            x_latched     <= 1'b0;
            o_px_x        <= '0;
            o_px_y        <= '0;
            o_px_valid    <= 1'b0;
            o_point_count <= '0;
        end else begin
            state       <= state_next;
            o_fifo_read <= (state_next == S_POP_X) || (state_next == S_POP_Y);

            // Read data is only guaranteed on the first CAP_X cycle; later wait cycles must not overwrite it.
            if (state == S_POP_X) begin
                x_latched <= 1'b0;
            end
            if (state == S_CAP_X && !x_latched) begin
                x_hold    <= i_fifo_data;
                x_latched <= 1'b1;
            end

            if (state == S_CAP_Y && !drop_point) begin
                o_px_x     <= x_hold;
                o_px_y     <= i_fifo_data;
                o_px_valid <= 1'b1;
            end

            if (state == S_OUT && i_px_ready) begin
                o_px_valid    <= 1'b0;
                o_point_count <= o_point_count + 1'b1;
            end
        end
    end

`ifdef PIXEL_CLIP_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_clip_count <= '0;
        end else if (state == S_CAP_Y && drop_point) begin
            o_clip_count <= o_clip_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pixel_drain.sv
// Self-checking bench for fifo_pixel_drain: a queue-based FIFO and scoreboard pair popped words
// into expected points, plus directed scenarios with hand-computed timing and values.
module tb_fifo_pixel_drain;

    localparam int DATA_W = 11;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty = 1'b1;
    logic              fifo_read;
    logic [DATA_W-1:0] px_x;
    logic [DATA_W-1:0] px_y;
    logic              px_valid;
    logic              px_ready;
    logic              busy;
    logic [CNT_W-1:0]  point_count;
`ifdef PIXEL_CLIP_EN
    logic [CNT_W-1:0]  clip_count;
    logic [CNT_W-1:0]  exp_clip = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus side appends words here; the model process moves them into the FIFO.
    logic [DATA_W-1:0] push_mem [0:4095];
    int                push_wr = 0;
    int                push_rd = 0;

    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] popped [$];
    logic [CNT_W-1:0]  exp_count = '0;
    logic              hold_pending = 1'b0;
    logic [DATA_W-1:0] hold_x = '0;
    logic [DATA_W-1:0] hold_y = '0;
    logic              prev_read = 1'b0;
    logic [DATA_W-1:0] tmp;

    fifo_pixel_drain #(
        .DATA_W(DATA_W), .H_RES(H_RES), .V_RES(V_RES), .CNT_W(CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_read  (fifo_read),
        .o_px_x       (px_x),
        .o_px_y       (px_y),
        .o_px_valid   (px_valid),
        .i_px_ready   (px_ready),
        .o_busy       (busy),
`ifdef PIXEL_CLIP_EN
        .o_clip_count (clip_count),
`endif
        .o_point_count(point_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        push_mem[push_wr] = w;
        push_wr++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!px_valid && n < 40) begin
            tick();
            n++;
        end
        if (!px_valid) check({name, "_timeout"}, {31'd0, px_valid}, 32'd1);
    endtask

    // FIFO model and scoreboard: every popped word is queued, each handshake must present the
    // oldest two popped words as (x, y); a reset forgets popped-but-unemitted words.
    always @(negedge clk) begin
        if (reset) begin
            popped.delete();
            exp_count    = '0;
            hold_pending = 1'b0;
            prev_read    = 1'b0;
`ifdef PIXEL_CLIP_EN
            exp_clip     = '0;
`endif
        end else begin
            check("point_count", {28'd0, point_count}, {28'd0, exp_count});
            if (fifo_read) check("read_while_empty", {31'd0, fifo_empty}, 32'd0);
            if (prev_read) check("read_back_to_back", {31'd0, fifo_read}, 32'd0);
            if (fifo_read || px_valid) check("busy_when_active", {31'd0, busy}, 32'd1);
`ifdef PIXEL_CLIP_EN
            check("clip_count", {28'd0, clip_count}, {28'd0, exp_clip});
            if (popped.size() >= 2 && (int'(popped[0]) >= H_RES || int'(popped[1]) >= V_RES)) begin
                tmp = popped.pop_front();
                tmp = popped.pop_front();
                exp_clip = exp_clip + 1'b1;
            end
`endif
            if (hold_pending) begin
                check("valid_held", {31'd0, px_valid}, 32'd1);
                check("x_held", {21'd0, px_x}, {21'd0, hold_x});
                check("y_held", {21'd0, px_y}, {21'd0, hold_y});
            end
            if (px_valid && px_ready) begin
                if (popped.size() >= 2) begin
                    check("point_x", {21'd0, px_x}, {21'd0, popped[0]});
                    check("point_y", {21'd0, px_y}, {21'd0, popped[1]});
                    tmp = popped.pop_front();
                    tmp = popped.pop_front();
                end else begin
                    check("point_has_source", popped.size(), 32'd2);
                end
                exp_count = exp_count + 1'b1;
            end
            hold_pending = px_valid && !px_ready;
            hold_x       = px_x;
            hold_y       = px_y;
            prev_read    = fifo_read;
        end
        if (fifo_read && !reset && fifo_q.size() > 0) begin
            tmp       = fifo_q.pop_front();
            fifo_data = tmp;
            popped.push_back(tmp);
        end
        while (push_rd < push_wr) begin
            fifo_q.push_back(push_mem[push_rd]);
            push_rd++;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rd_mask;
        logic [5:0] vl_mask;
        logic [DATA_W-1:0] x5;
        logic [DATA_W-1:0] y5;
        int reads_seen;
        int stuck;

        reset    = 1'b1;
        enable   = 1'b0;
        px_ready = 1'b0;
        x5       = '0;
        y5       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
        check("rst_px_x", {21'd0, px_x}, 32'd0);
        check("rst_px_y", {21'd0, px_y}, 32'd0);
        check("rst_px_valid", {31'd0, px_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_point_count", {28'd0, point_count}, 32'd0);

        // Single pair 10,20 with ready high: pops on edges 1 and 3, valid on edge 5.
        reset = 1'b0;
        push(11'd10);
        push(11'd20);
        tick();
        check("t1_idle_when_disabled", {31'd0, busy}, 32'd0);
        enable   = 1'b1;
        px_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            rd_mask[n] = fifo_read;
            vl_mask[n] = px_valid;
            if (n == 4) begin
                x5 = px_x;
                y5 = px_y;
            end
        end
        check("t1_read_pulses", {26'd0, rd_mask}, 32'b000101);
        check("t1_valid_pulse", {26'd0, vl_mask}, 32'b010000);
        check("t1_x", {21'd0, x5}, 32'd10);
        check("t1_y", {21'd0, y5}, 32'd20);
        check("t1_count", {28'd0, point_count}, 32'd1);
        check("t1_back_to_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: point (1,2) held for 6 cycles, then (3,4).
        do_reset();
        px_ready = 1'b0;
        push(11'd1); push(11'd2); push(11'd3); push(11'd4);
        wait_valid("t2_first");
        for (int n = 0; n < 6; n++) begin
            check("t2_hold_valid", {31'd0, px_valid}, 32'd1);
            check("t2_hold_x", {21'd0, px_x}, 32'd1);
            check("t2_hold_y", {21'd0, px_y}, 32'd2);
            check("t2_no_pop", {31'd0, fifo_read}, 32'd0);
            if (n < 5) tick();
        end
        px_ready = 1'b1;
        tick();
        wait_valid("t2_second");
        check("t2_x2", {21'd0, px_x}, 32'd3);
        check("t2_y2", {21'd0, px_y}, 32'd4);
        tick();
        check("t2_count", {28'd0, point_count}, 32'd2);

        // Odd word count: X=7 popped, then wait in CAP_X until 9 arrives.
        do_reset();
        push(11'd7);
        reads_seen = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            reads_seen += int'(fifo_read);
        end
        check("t3_single_pop", reads_seen, 32'd1);
        check("t3_waiting_busy", {31'd0, busy}, 32'd1);
        check("t3_no_read", {31'd0, fifo_read}, 32'd0);
        check("t3_no_valid", {31'd0, px_valid}, 32'd0);
        push(11'd9);
        wait_valid("t3_point");
        check("t3_x", {21'd0, px_x}, 32'd7);
        check("t3_y", {21'd0, px_y}, 32'd9);
        tick();

        // Asynchronous reset while a point is waiting in OUT.
        do_reset();
        px_ready = 1'b0;
        for (int w = 1; w <= 6; w++) push(11'(w));
        wait_valid("t4_first");
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
        wait_valid("t4_second");
        check("t4_second_x", {21'd0, px_x}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t4_async_valid", {31'd0, px_valid}, 32'd0);
        check("t4_async_busy", {31'd0, busy}, 32'd0);
        check("t4_async_count", {28'd0, point_count}, 32'd0);
        tick();
        reset    = 1'b0;
        px_ready = 1'b1;
        wait_valid("t4_after_reset");
        check("t4_x", {21'd0, px_x}, 32'd5);
        check("t4_y", {21'd0, px_y}, 32'd6);
        tick();
        check("t4_count", {28'd0, point_count}, 32'd1);

        // Disabled drain: no pops until enable rises, then POP_X on the next edge.
        do_reset();
        enable = 1'b0;
        push(11'd11);
        push(11'd12);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("t5_no_pop", {31'd0, fifo_read}, 32'd0);
            check("t5_not_busy", {31'd0, busy}, 32'd0);
        end
        enable = 1'b1;
        tick();
        check("t5_start_busy", {31'd0, busy}, 32'd1);
        check("t5_start_read", {31'd0, fifo_read}, 32'd1);
        wait_valid("t5_point");
        check("t5_x", {21'd0, px_x}, 32'd11);
        check("t5_y", {21'd0, px_y}, 32'd12);
        tick();

`ifdef PIXEL_CLIP_EN
        // (700,5) is out of range and dropped; (5,5) is emitted.
        do_reset();
        push(11'd700); push(11'd5); push(11'd5); push(11'd5);
        wait_valid("clip_point");
        check("clip_x", {21'd0, px_x}, 32'd5);
        check("clip_y", {21'd0, px_y}, 32'd5);
        check("clip_dropped", {28'd0, clip_count}, 32'd1);
        tick();
        check("clip_count_points", {28'd0, point_count}, 32'd1);
`endif

        // Randomised traffic; the scoreboard checks every cycle, including counter wrap.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) push(11'($urandom_range(0, (1 << DATA_W) - 1)));
            px_ready = ($urandom_range(0, 2) != 0);
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            tick();
        end

        // Drain: pad an odd leftover word so the last point can complete.
        enable   = 1'b1;
        px_ready = 1'b1;
        stuck    = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (busy && fifo_empty && !fifo_read && !px_valid) stuck++;
            else stuck = 0;
            if (stuck == 10) push(11'd0);
            if (!busy && fifo_empty && push_rd == push_wr && n > 20) break;
        end
        check("drain_idle", {31'd0, busy}, 32'd0);
        check("drain_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
